// File: rtl/branch_cond_unit_pkg.sv
// Shared encodings for the branch condition path: condition codes, flag bit positions, FSM states.
package branch_cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/branch_cond_unit_cond_check.sv
// Combinational condition-code evaluator over {Z,N,C,V}; zero latency, no flow control.
// Also usable by predicated-execute logic.
module branch_cond_unit_cond_check
  import branch_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, n, c, v;

  always_comb begin
    z    = flags[FLAG_Z];
    n    = flags[FLAG_N];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Resolves one conditional branch at a time once all older flag writers commit; issues redirect + flush.
// br_done 2 cycles after accept when nothing pending; br_ready stays low until the branch (and flush) retires.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int PEND_W       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        flags_in,
  input  logic              flag_issue,
  input  logic              flag_commit,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_done,
  output logic              br_taken,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              pend_err
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
  logic              pend_err_q, pend_err_d;
  logic [PEND_W:0]   wait_cnt_q, wait_cnt_d;
  logic [PEND_W:0]   wait_init;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              taken_q, taken_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              br_ready_q, br_ready_d;
  logic              br_done_q, br_done_d;
  logic              br_taken_q, br_taken_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              cond_pass;

  branch_cond_unit_cond_check u_cond_check (
    .cond  (cond_q),
    .flags (flags_in),
    .pass  (cond_pass)
  );

  always_comb begin
    state_d          = state_q;
    pend_cnt_d       = pend_cnt_q;
    pend_err_d       = pend_err_q;
    wait_cnt_d       = wait_cnt_q;
    cond_d           = cond_q;
    target_d         = target_q;
    taken_d          = taken_q;
    flush_cnt_d      = flush_cnt_q;
    br_ready_d       = br_ready_q;
    br_done_d        = 1'b0;
    br_taken_d       = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;

    if (flag_issue && !flag_commit) begin
      if (pend_cnt_q == PEND_MAX) pend_err_d = 1'b1;
      else                        pend_cnt_d = pend_cnt_q + PEND_W'(1);
    end else if (flag_commit && !flag_issue) begin
      if (pend_cnt_q == '0) pend_err_d = 1'b1;
      else                  pend_cnt_d = pend_cnt_q - PEND_W'(1);
    end

    // Writers older than the branch: everything pending plus a same-cycle issue, less a same-cycle commit.
    wait_init = {1'b0, pend_cnt_q} + {{PEND_W{1'b0}}, flag_issue};
    if (flag_commit && wait_init != '0) wait_init = wait_init - (PEND_W + 1)'(1);

    case (state_q)
      ST_IDLE: begin
        br_ready_d = 1'b1;
        if (br_valid && br_ready_q) begin
          cond_d     = br_cond;
          target_d   = br_target;
          wait_cnt_d = wait_init;
          br_ready_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Flags are read only in a cycle after the last commit edge, once the status register has settled.
        if (flag_commit) begin
          if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - (PEND_W + 1)'(1);
        end else if (wait_cnt_q == '0) begin
          taken_d          = cond_pass;
          br_done_d        = 1'b1;
          br_taken_d       = cond_pass;
          redirect_valid_d = cond_pass;
          redirect_pc_d    = target_q;
          state_d          = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (taken_q && (FLUSH_CYCLES > 0)) begin
          flush_d     = 1'b1;
          flush_cnt_d = FL_W'(FLUSH_CYCLES - 1);
          state_d     = ST_FLUSH;
        end else begin
          br_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d    = 1'b0;
          br_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      pend_cnt_q       <= '0;
      pend_err_q       <= 1'b0;
      wait_cnt_q       <= '0;
      cond_q           <= '0;
      target_q         <= '0;
      taken_q          <= 1'b0;
      flush_cnt_q      <= '0;
      br_ready_q       <= 1'b0;
      br_done_q        <= 1'b0;
      br_taken_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_cnt_q       <= pend_cnt_d;
      pend_err_q       <= pend_err_d;
      wait_cnt_q       <= wait_cnt_d;
      cond_q           <= cond_d;
      target_q         <= target_d;
      taken_q          <= taken_d;
      flush_cnt_q      <= flush_cnt_d;
      br_ready_q       <= br_ready_d;
      br_done_q        <= br_done_d;
      br_taken_q       <= br_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
    end
  end

  assign br_ready       = br_ready_q;
  assign br_done        = br_done_q;
  assign br_taken       = br_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign pend_err       = pend_err_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: condition truth table sweep plus hand-built ordering/reset/saturation sequences.
module tb_branch_cond_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        flags_in = '0;
  logic              flag_issue = 1'b0;
  logic              flag_commit = 1'b0;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic [3:0]        br_cond = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              br_done;
  logic              br_taken;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic              pend_err;

  branch_cond_unit #(.ADDR_W(ADDR_W), .PEND_W(3), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .flags_in       (flags_in),
    .flag_issue     (flag_issue),
    .flag_commit    (flag_commit),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .br_done        (br_done),
    .br_taken       (br_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .pend_err       (pend_err)
  );

  always #5 clk = ~clk;

  // Truth mask per condition: bit f is the expected outcome for flags {Z,N,C,V} == f.
  typedef struct {
    logic [3:0]  cond;
    logic [15:0] mask;
  } vec_t;

  vec_t vecs [16];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  64'(br_ready), 64'd0);
    chk({tag, "_done"},   64'(br_done), 64'd0);
    chk({tag, "_taken"},  64'(br_taken), 64'd0);
    chk({tag, "_rvalid"}, 64'(redirect_valid), 64'd0);
    chk({tag, "_rpc"},    64'(redirect_pc), 64'd0);
    chk({tag, "_flush"},  64'(flush), 64'd0);
    chk({tag, "_perr"},   64'(pend_err), 64'd0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (br_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // lat = edges from the accept edge to the first cycle br_done is visible.
  task automatic run_branch(input logic [3:0] c, input logic [ADDR_W-1:0] t, output bit done,
                            output logic tk, output logic rv, output logic [ADDR_W-1:0] pc, output int lat);
    bit ok;
    done = 1'b0; tk = 1'b0; rv = 1'b0; pc = '0; lat = 0;
    wait_ready(ok);
    if (!ok) return;
    br_valid = 1'b1; br_cond = c; br_target = t;
    step();
    br_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (br_done) begin
        done = 1'b1; tk = br_taken; rv = redirect_valid; pc = redirect_pc;
        break;
      end
      step();
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit                done, ok;
    logic              tk, rv;
    logic [ADDR_W-1:0] pc;
    int                lat;

    vecs[0]  = '{4'h0, 16'hFF00};  // EQ
    vecs[1]  = '{4'h1, 16'h00FF};  // NE
    vecs[2]  = '{4'h2, 16'hCCCC};  // CS
    vecs[3]  = '{4'h3, 16'h3333};  // CC
    vecs[4]  = '{4'h4, 16'hF0F0};  // MI
    vecs[5]  = '{4'h5, 16'h0F0F};  // PL
    vecs[6]  = '{4'h6, 16'hAAAA};  // VS
    vecs[7]  = '{4'h7, 16'h5555};  // VC
    vecs[8]  = '{4'h8, 16'h00CC};  // HI
    vecs[9]  = '{4'h9, 16'hFF33};  // LS
    vecs[10] = '{4'hA, 16'hA5A5};  // GE
    vecs[11] = '{4'hB, 16'h5A5A};  // LT
    vecs[12] = '{4'hC, 16'h00A5};  // GT
    vecs[13] = '{4'hD, 16'hFF5A};  // LE
    vecs[14] = '{4'hE, 16'hFFFF};  // AL
    vecs[15] = '{4'hF, 16'h0000};  // NV

    // Reset state, then ready one edge after release
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready_pre", 64'(br_ready), 64'd0);
    step();
    chk("rel_ready", 64'(br_ready), 64'd1);

    // BEQ with Z set, nothing pending: done at accept+2, then 2 flush cycles
    flags_in = 4'b1000;
    br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h40;
    step();
    br_valid = 1'b0;
    chk("beq_ready_low", 64'(br_ready), 64'd0);
    chk("beq_done_early", 64'(br_done), 64'd0);
    step();
    chk("beq_done", 64'(br_done), 64'd1);
    chk("beq_taken", 64'(br_taken), 64'd1);
    chk("beq_rvalid", 64'(redirect_valid), 64'd1);
    chk("beq_rpc", 64'(redirect_pc), 64'h40);
    step();
    chk("beq_done_pulse", 64'(br_done), 64'd0);
    chk("beq_rvalid_pulse", 64'(redirect_valid), 64'd0);
    chk("beq_flush1", 64'(flush), 64'd1);
    step();
    chk("beq_flush2", 64'(flush), 64'd1);
    step();
    chk("beq_flush_end", 64'(flush), 64'd0);
    chk("beq_ready_back", 64'(br_ready), 64'd1);
    chk("beq_rpc_hold", 64'(redirect_pc), 64'h40);

    // Two older writers: BNE resolves on the flags after the second commit
    flag_issue = 1'b1;
    step(); step();
    flag_issue = 1'b0;
    flags_in = 4'b1000;
    br_valid = 1'b1; br_cond = 4'h1; br_target = 32'h1234;
    step();
    br_valid = 1'b0;
    step(); step();
    chk("bne_wait0", 64'(br_done), 64'd0);
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    step(); step();
    chk("bne_wait1", 64'(br_done), 64'd0);
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    flags_in = 4'b0000;
    chk("bne_wait2", 64'(br_done), 64'd0);
    step();
    chk("bne_done", 64'(br_done), 64'd1);
    chk("bne_taken", 64'(br_taken), 64'd1);
    chk("bne_rpc", 64'(redirect_pc), 64'h1234);
    wait_ready(ok);
    chk("bne_ready_back", 64'(ok), 64'd1);

    // Same-cycle issue is older; a later issue is younger and ignored
    flags_in = 4'b0001;
    flag_issue = 1'b1;
    br_valid = 1'b1; br_cond = 4'h6; br_target = 32'h88;
    step();
    br_valid = 1'b0;
    step();
    flag_issue = 1'b0;
    step(); step();
    chk("young_wait", 64'(br_done), 64'd0);
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    chk("young_wait_c", 64'(br_done), 64'd0);
    step();
    chk("young_done", 64'(br_done), 64'd1);
    chk("young_taken", 64'(br_taken), 64'd1);
    flag_commit = 1'b1;  // retire the younger writer
    step();
    flag_commit = 1'b0;
    chk("young_no_err", 64'(pend_err), 64'd0);
    wait_ready(ok);

    // Full truth-table sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        flags_in = 4'(f);
        run_branch(vecs[c].cond, 32'h1000 + 32'(c * 16 + f), done, tk, rv, pc, lat);
        chk($sformatf("sweep_done c%0d f%0d", c, f), 64'(done), 64'd1);
        chk($sformatf("sweep_taken c%0d f%0d", c, f), 64'(tk), 64'(vecs[c].mask[f]));
        chk($sformatf("sweep_rvalid c%0d f%0d", c, f), 64'(rv), 64'(vecs[c].mask[f]));
        chk($sformatf("sweep_lat c%0d f%0d", c, f), 64'(lat), 64'd2);
        if (vecs[c].mask[f]) chk($sformatf("sweep_rpc c%0d f%0d", c, f), 64'(pc), 64'(32'h1000 + 32'(c * 16 + f)));
      end
    end
    wait_ready(ok);
    chk("sweep_end_ready", 64'(ok), 64'd1);

    // Reset during WAIT abandons the branch
    flag_issue = 1'b1;
    step();
    flag_issue = 1'b0;
    br_valid = 1'b1; br_cond = 4'hE; br_target = 32'h55;
    step();
    br_valid = 1'b0;
    step();
    chk("rw_waiting", 64'(br_done), 64'd0);
    reset = 1'b0;
    #1;
    chk("rw_ready0", 64'(br_ready), 64'd0);
    chk("rw_done0", 64'(br_done), 64'd0);
    chk("rw_rpc0", 64'(redirect_pc), 64'd0);
    step();
    #2 reset = 1'b1;
    step();
    chk("rw_ready1", 64'(br_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_redirect", 64'(redirect_valid), 64'd0);
      step();
    end

    // Reset during FLUSH
    flags_in = 4'b0000;
    run_branch(4'hE, 32'h77, done, tk, rv, pc, lat);
    chk("rf_taken", 64'(tk), 64'd1);
    step();
    chk("rf_in_flush", 64'(flush), 64'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("rf");
    #2 reset = 1'b1;
    step();
    chk("rf_ready1", 64'(br_ready), 64'd1);
    chk("rf_flush_off", 64'(flush), 64'd0);

    // Counter saturation at max: 8 issues keep 7 outstanding, err sticky
    flag_issue = 1'b1;
    for (int i = 0; i < 7; i++) step();
    flag_issue = 1'b0;
    chk("sat_no_err7", 64'(pend_err), 64'd0);
    flag_issue = 1'b1;
    step();
    flag_issue = 1'b0;
    chk("sat_err", 64'(pend_err), 64'd1);
    br_valid = 1'b1; br_cond = 4'hE; br_target = 32'h99;
    step();
    br_valid = 1'b0;
    flag_commit = 1'b1;
    for (int i = 0; i < 6; i++) step();
    flag_commit = 1'b0;
    step(); step();
    chk("sat_wait7", 64'(br_done), 64'd0);
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    step();
    chk("sat_done", 64'(br_done), 64'd1);
    chk("sat_err_sticky", 64'(pend_err), 64'd1);
    wait_ready(ok);

    // Underflow on commit at zero sets err
    reset = 1'b0;
    #1;
    chk("uf_err_clr", 64'(pend_err), 64'd0);
    #2 reset = 1'b1;
    step();
    flag_commit = 1'b1;
    step();
    flag_commit = 1'b0;
    chk("uf_err", 64'(pend_err), 64'd1);
    step(); step();
    chk("uf_err_sticky", 64'(pend_err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
